fifo_status: RTL

- Occupancy and flag generator for the synchronous FIFO.
- Consumes the qualified write strobe from the write-pointer stage and the qualified read strobe from the read-pointer stage.
- Produces the registered fifo_full that gates the write-pointer stage, and the fifo_empty that gates the read-pointer stage.
- Also provides watermark flags, a fill count and sticky overflow/underflow error flags for the systolic-array data feeders.

---
 rtl/fifo_status.sv | 110 +++++++++++
 1 files changed

// File: rtl/fifo_status.sv
// Occupancy, watermark and sticky error flag generator for the synchronous FIFO.
// Optional high-water-mark output enabled by defining FIFO_STATUS_HWM_EN.
module fifo_status #(
  parameter int PTR_LENGTH      = 5,
  parameter int ALMOST_FULL_TH  = 28,
  parameter int ALMOST_EMPTY_TH = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                write,
  input  logic                read,
  input  logic                fifo_write,
  input  logic                fifo_read,
  input  logic                clr_err,
  output logic                fifo_full,
  output logic                fifo_empty,
  output logic                almost_full,
  output logic                almost_empty,
  output logic [PTR_LENGTH:0] count,
  output logic                overflow,
`ifdef FIFO_STATUS_HWM_EN
  output logic                underflow,
  output logic [PTR_LENGTH:0] hwm
`else
  output logic                underflow
`endif
);

  localparam int DEPTH = 2 ** PTR_LENGTH;
  localparam logic [PTR_LENGTH:0] DEPTH_C = (PTR_LENGTH + 1)'(DEPTH);
  localparam logic [PTR_LENGTH:0] AF_TH_C = (PTR_LENGTH + 1)'(ALMOST_FULL_TH);
  localparam logic [PTR_LENGTH:0] AE_TH_C = (PTR_LENGTH + 1)'(ALMOST_EMPTY_TH);

  logic [PTR_LENGTH:0] count_q, count_d;
  logic                full_q, full_d;
  logic                empty_q, empty_d;
  logic                afull_q, afull_d;
  logic                aempty_q, aempty_d;
  logic                overflow_q, overflow_d;
  logic                underflow_q, underflow_d;

  // Flags come from the next count so they line up with the count they describe.
  always_comb begin
    count_d = count_q;
    if (fifo_write && !fifo_read && count_q != DEPTH_C) begin
      count_d = count_q + 1'b1;
    end else if (fifo_read && !fifo_write && count_q != '0) begin
      count_d = count_q - 1'b1;
    end
    full_d      = (count_d == DEPTH_C);
    empty_d     = (count_d == '0);
    afull_d     = (count_d >= AF_TH_C);
    aempty_d    = (count_d <= AE_TH_C);
    overflow_d  = (overflow_q  && !clr_err) || (write && full_q);
    underflow_d = (underflow_q && !clr_err) || (read && empty_q);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q     <= '0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      afull_q     <= 1'b0;
      aempty_q    <= 1'b1;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      full_q      <= full_d;
      empty_q     <= empty_d;
      afull_q     <= afull_d;
      aempty_q    <= aempty_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign count        = count_q;
  assign fifo_full    = full_q;
  assign fifo_empty   = empty_q;
  assign almost_full  = afull_q;
  assign almost_empty = aempty_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

`ifdef FIFO_STATUS_HWM_EN
  logic [PTR_LENGTH:0] hwm_q, hwm_d;

  // clr_err restarts the peak tracking from the occupancy being entered.
  always_comb begin
    hwm_d = hwm_q;
    if (clr_err) begin
      hwm_d = count_d;
    end else if (count_d > hwm_q) begin
      hwm_d = count_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hwm_q <= '0;
    end else begin
      hwm_q <= hwm_d;
    end
  end

  assign hwm = hwm_q;
`endif

endmodule
